// File: rtl/oam_sram.sv
// ============================================================================
// Module   : oam_sram
// Purpose  : 160-byte sprite attribute RAM, two 80x8 banks (even/odd bytes),
//            with strobe-committed writes, oam_clk read latches and CPU drive.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_sram_bank #(
  parameter int WORDS   = 80,
  parameter int INIT_FF = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] word_addr,
  input  logic       latch,
  input  logic       ncs,
  input  logic       cpu_nrd,
  input  logic [7:0] nd_in,
  output logic [7:0] nd_out,
  output logic       nd_oe,
  output logic [7:0] q
);

  localparam logic [7:0] c_words = 8'(WORDS);

  logic       r_prev_ncs;
  logic [6:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_q;
  logic       r_oe;
  logic [7:0] r_mem [0:WORDS-1];

  logic w_commit;
  logic w_wr_ok;
  logic w_rd_ok;

  // The commit fires on the clk that first sees the strobe high again.
  assign w_commit = ncs & ~r_prev_ncs;
  assign w_wr_ok  = ({1'b0, r_wr_addr} < c_words);
  assign w_rd_ok  = ({1'b0, word_addr} < c_words);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_ncs <= 1'b1;
      r_wr_addr  <= 7'd0;
      r_wr_data  <= 8'd0;
      r_q        <= 8'hFF;
      r_oe       <= 1'b0;
    end else begin
      r_prev_ncs <= ncs;
      if (!ncs) begin
        r_wr_addr <= word_addr;
        r_wr_data <= ~nd_in;
      end
      // Non-blocking read of r_mem gives read-before-write on a shared clk.
      if (latch) begin
        r_q <= w_rd_ok ? r_mem[word_addr] : 8'hFF;
      end
      r_oe <= ~cpu_nrd & ncs;
    end
  end

  generate
    if (INIT_FF != 0) begin : g_mem_init
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < WORDS; i++) begin
            r_mem[i] <= 8'hFF;
          end
        end else if (w_commit && w_wr_ok) begin
          r_mem[r_wr_addr] <= r_wr_data;
        end
      end
    end else begin : g_mem_keep
      always_ff @(posedge clk) begin
        if (w_commit && w_wr_ok) begin
          r_mem[r_wr_addr] <= r_wr_data;
        end
      end
    end
  endgenerate

  assign q      = r_q;
  assign nd_out = ~r_q;
  assign nd_oe  = r_oe;

endmodule

module oam_sram #(
  parameter int WORDS   = 80,
  parameter int INIT_FF = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] oam_a,
  input  logic       oam_clk,
  input  logic       oam_a_ncs,
  input  logic       oam_b_ncs,
  input  logic       oam_a_cpu_nrd,
  input  logic       oam_b_cpu_nrd,
  input  logic [7:0] oam_a_nd_in,
  input  logic [7:0] oam_b_nd_in,
  output logic [7:0] oam_a_nd_out,
  output logic       oam_a_nd_oe,
  output logic [7:0] oam_b_nd_out,
  output logic       oam_b_nd_oe,
  output logic [7:0] oam_q_a,
  output logic [7:0] oam_q_b
);

  logic r_prev_oam_clk;
  logic w_latch;
  logic w_unused_a0;

  // Bank is chosen by the strobes, so the byte-select bit is not used.
  assign w_unused_a0 = oam_a[0];
  assign w_latch     = oam_clk & ~r_prev_oam_clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_oam_clk <= 1'b1;
    end else begin
      r_prev_oam_clk <= oam_clk;
    end
  end

  oam_sram_bank #(.WORDS(WORDS), .INIT_FF(INIT_FF)) u_bank_a (
    .clk       (clk),
    .reset     (reset),
    .word_addr (oam_a[7:1]),
    .latch     (w_latch),
    .ncs       (oam_a_ncs),
    .cpu_nrd   (oam_a_cpu_nrd),
    .nd_in     (oam_a_nd_in),
    .nd_out    (oam_a_nd_out),
    .nd_oe     (oam_a_nd_oe),
    .q         (oam_q_a)
  );

  oam_sram_bank #(.WORDS(WORDS), .INIT_FF(INIT_FF)) u_bank_b (
    .clk       (clk),
    .reset     (reset),
    .word_addr (oam_a[7:1]),
    .latch     (w_latch),
    .ncs       (oam_b_ncs),
    .cpu_nrd   (oam_b_cpu_nrd),
    .nd_in     (oam_b_nd_in),
    .nd_out    (oam_b_nd_out),
    .nd_oe     (oam_b_nd_oe),
    .q         (oam_q_b)
  );

endmodule

`default_nettype wire

// File: tb/tb_oam_sram.sv
// ============================================================================
// Module   : tb_oam_sram
// Purpose  : Directed self-checking bench for oam_sram.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oam_sram;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] oam_a;
  logic       oam_clk;
  logic       oam_a_ncs;
  logic       oam_b_ncs;
  logic       oam_a_cpu_nrd;
  logic       oam_b_cpu_nrd;
  logic [7:0] oam_a_nd_in;
  logic [7:0] oam_b_nd_in;
  logic [7:0] oam_a_nd_out;
  logic       oam_a_nd_oe;
  logic [7:0] oam_b_nd_out;
  logic       oam_b_nd_oe;
  logic [7:0] oam_q_a;
  logic [7:0] oam_q_b;

  int total = 0;
  int bad   = 0;

  oam_sram #(.WORDS(80), .INIT_FF(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .oam_a         (oam_a),
    .oam_clk       (oam_clk),
    .oam_a_ncs     (oam_a_ncs),
    .oam_b_ncs     (oam_b_ncs),
    .oam_a_cpu_nrd (oam_a_cpu_nrd),
    .oam_b_cpu_nrd (oam_b_cpu_nrd),
    .oam_a_nd_in   (oam_a_nd_in),
    .oam_b_nd_in   (oam_b_nd_in),
    .oam_a_nd_out  (oam_a_nd_out),
    .oam_a_nd_oe   (oam_a_nd_oe),
    .oam_b_nd_out  (oam_b_nd_out),
    .oam_b_nd_oe   (oam_b_nd_oe),
    .oam_q_a       (oam_q_a),
    .oam_q_b       (oam_q_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Low phase then rising edge of oam_clk: the latch happens on the second clk.
  task automatic pulse_oam(input logic [7:0] addr);
    oam_a   = addr;
    oam_clk = 1'b0;
    tick();
    oam_clk = 1'b1;
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    oam_a         = 8'h00;
    oam_clk       = 1'b1;
    oam_a_ncs     = 1'b1;
    oam_b_ncs     = 1'b1;
    oam_a_cpu_nrd = 1'b1;
    oam_b_cpu_nrd = 1'b1;
    oam_a_nd_in   = 8'hFF;
    oam_b_nd_in   = 8'hFF;
    #2;
    chk("rst_q_a", oam_q_a, 8'hFF);
    chk("rst_q_b", oam_q_b, 8'hFF);
    chk("rst_oe_a", {7'd0, oam_a_nd_oe}, 8'h00);
    chk("rst_oe_b", {7'd0, oam_b_nd_oe}, 8'h00);
    chk("rst_nd_a_out", oam_a_nd_out, 8'h00);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Fresh memory reads all-ones.
    pulse_oam(8'h00);
    chk("init_q_a", oam_q_a, 8'hFF);
    chk("init_q_b", oam_q_b, 8'hFF);

    // Two capture cycles; the second (word 8, ~A5) must win over word 16.
    oam_a       = 8'h20;
    oam_a_nd_in = 8'h12;
    oam_a_ncs   = 1'b0;
    tick();
    oam_a       = 8'h10;
    oam_a_nd_in = 8'hA5;
    tick();
    oam_a_ncs = 1'b1;
    tick();
    pulse_oam(8'h10);
    chk("wr_q_a", oam_q_a, 8'h5A);
    chk("wr_q_b_untouched", oam_q_b, 8'hFF);
    oam_a_cpu_nrd = 1'b0;
    tick();
    chk("rd_oe_a", {7'd0, oam_a_nd_oe}, 8'h01);
    chk("rd_nd_a_out", oam_a_nd_out, 8'hA5);
    chk("rd_oe_b_idle", {7'd0, oam_b_nd_oe}, 8'h00);
    pulse_oam(8'h20);
    chk("last_wins_w16", oam_q_a, 8'hFF);

    // Bank B: word 0x4F gets 0x11, then an out-of-range write to word 80.
    oam_a       = 8'h9E;
    oam_b_nd_in = 8'hEE;
    oam_b_ncs   = 1'b0;
    tick();
    oam_b_ncs = 1'b1;
    tick();
    oam_a       = 8'hA0;
    oam_b_nd_in = 8'hC3;
    oam_b_ncs   = 1'b0;
    tick();
    oam_b_ncs = 1'b1;
    tick();
    pulse_oam(8'hA0);
    chk("oor_q_b", oam_q_b, 8'hFF);
    chk("oor_q_a", oam_q_a, 8'hFF);
    pulse_oam(8'h9E);
    chk("w4f_q_b", oam_q_b, 8'h11);
    pulse_oam(8'h20);
    chk("no_alias_w16_b", oam_q_b, 8'hFF);

    // Word 3 holds 0x21; commit 0x77 on the same clk as a latch.
    oam_a       = 8'h06;
    oam_a_nd_in = 8'hDE;
    oam_a_ncs   = 1'b0;
    tick();
    oam_a_ncs = 1'b1;
    tick();
    oam_a_nd_in = 8'h88;
    oam_a_ncs   = 1'b0;
    oam_clk     = 1'b0;
    tick();
    oam_a_ncs = 1'b1;
    oam_clk   = 1'b1;
    tick();
    chk("rbw_old", oam_q_a, 8'h21);
    tick();
    chk("latch_hold", oam_q_a, 8'h21);
    pulse_oam(8'h06);
    chk("rbw_new", oam_q_a, 8'h77);

    // Reset lands during a pending write; the strobe rise must not commit.
    oam_a       = 8'h10;
    oam_a_nd_in = 8'h5A;
    oam_a_ncs   = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_q_a", oam_q_a, 8'hFF);
    chk("midrst_oe_a", {7'd0, oam_a_nd_oe}, 8'h00);
    #1;
    reset     = 1'b0;
    oam_a_ncs = 1'b1;
    tick();
    tick();
    pulse_oam(8'h10);
    chk("midrst_no_commit", oam_q_a, 8'hFF);
    pulse_oam(8'h06);
    chk("midrst_mem_init", oam_q_a, 8'hFF);

    // Write select dominates the CPU read enable.
    oam_a         = 8'h30;
    oam_a_nd_in   = 8'hFF;
    oam_a_cpu_nrd = 1'b0;
    oam_a_ncs     = 1'b0;
    tick();
    chk("dom_oe_a_off", {7'd0, oam_a_nd_oe}, 8'h00);
    oam_a_ncs = 1'b1;
    tick();
    chk("dom_oe_a_on", {7'd0, oam_a_nd_oe}, 8'h01);
    chk("dom_nd_a_out", oam_a_nd_out, 8'h00);
    chk("dom_oe_b_idle", {7'd0, oam_b_nd_oe}, 8'h00);
    oam_b_cpu_nrd = 1'b0;
    tick();
    chk("oe_b_on", {7'd0, oam_b_nd_oe}, 8'h01);
    chk("nd_b_out", oam_b_nd_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
